// File: rtl/uart_replayer.sv
// uart_replayer: UART echo engine for replay mode.
// While activate is high, every byte from uart_rx is buffered in a circular
// FIFO and re-sent through uart_tx in arrival order. A session ends when the
// terminator byte has been accepted, echoed, and its frame has completed.
// The block then holds done until activate falls.
// Optional feature: define UART_REPLAYER_UPPERCASE_EN to echo 'a'..'z' as
// upper case. Terminator detection always uses the raw received byte.
module uart_replayer #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  TERM_BYTE = 8'h1B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    output logic       done,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT_TX,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          term_seen_q, term_seen_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic [7:0]    mem [DEPTH];

    logic          buf_empty;
    logic          buf_full;
    logic          rx_take;
    logic          push;
    logic          pop;
    logic          term_now;

    // Byte transformation applied on the way into the buffer.
    function automatic logic [7:0] echo_byte(input logic [7:0] b);
`ifdef UART_REPLAYER_UPPERCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b & 8'hDF;
        end
        return b;
`else
        return b;
`endif
    endfunction

    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == FULL_CNT);

    // Receive is open in RUN/WAIT_TX until the terminator has been accepted;
    // a launch needs a queued byte, no frame outstanding and an idle uart_tx.
    assign rx_take  = activate && rx_ready && !term_seen_q &&
                      (state_q == RUN || state_q == WAIT_TX);
    assign push     = rx_take && !buf_full;
    assign term_now = push && (rx_data == TERM_BYTE);
    assign pop      = activate && !buf_empty && !tx_active &&
                      (state_q == RUN || state_q == DRAIN);

    // Next-state logic; activate low overrides everything and returns to IDLE.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (activate) state_d = RUN;
            end
            RUN: begin
                if (pop)           state_d = WAIT_TX;
                else if (term_now) state_d = DRAIN;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    // The terminator echo just finished: nothing can be left.
                    if (term_seen_q && buf_empty)     state_d = DONE;
                    else if (term_seen_q || term_now) state_d = DRAIN;
                    else                              state_d = RUN;
                end
            end
            DRAIN: begin
                if (pop)            state_d = WAIT_TX;
                else if (buf_empty) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (!activate) state_d = IDLE;
        done_d = (state_d == DONE);
    end

    // Buffer bookkeeping, sticky flags and the registered transmit interface.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        term_seen_d = term_seen_q;
        overflow_d  = overflow_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = pop;
        if (state_q == IDLE) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            term_seen_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                tx_data_d = mem[rd_ptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (rx_take && buf_full) overflow_d  = 1'b1;
            if (term_now)            term_seen_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            term_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            term_seen_q <= term_seen_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count and pointers define which
        // entries are valid, so stale contents are never observed.
        if (push) mem[wr_ptr_q] <= echo_byte(rx_data);
    end

    assign done     = done_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_replayer.sv
// Self-checking bench for uart_replayer: directed steps in one initial block,
// a behavioural uart_tx model that can be stalled, and a scoreboard of
// expected echo bytes popped on every tx_start.
module tb_uart_replayer;

    localparam int TX_CYC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       activate = 1'b0;
    logic       done;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       overflow;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         tx_count = 0;
    int         last_start_cyc = 0;
    int         rx_cyc = 0;
    int         busy = 0;
    int         base = 0;
    logic       tx_stall = 1'b0;
    logic [7:0] bv;
    logic [7:0] exp_q[$];

    uart_replayer dut (
        .clk       (clk),
        .reset     (reset),
        .activate  (activate),
        .done      (done),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_echo(input logic [7:0] b);
`ifdef UART_REPLAYER_UPPERCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return {b[7:6], 1'b0, b[4:0]};
`endif
        return b;
    endfunction

    // uart_tx model plus scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        logic pending;
        cyc++;
        if (tx_done) tx_done = 1'b0;
        if (tx_start === 1'b1) begin
            tx_count++;
            last_start_cyc = cyc;
            check("tx_idle_at_start", {31'd0, tx_active}, 32'd0);
            pending = (exp_q.size() > 0);
            check("tx_start_expected", {31'd0, pending}, 32'd1);
            if (pending) check("echo_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            tx_active = 1'b1;
            busy = TX_CYC;
        end else if (tx_active && !tx_stall) begin
            if (busy == 0) begin
                tx_active = 1'b0;
                tx_done   = 1'b1;
            end else begin
                busy--;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        #1;
        rx_data  = b;
        rx_ready = 1'b1;
        rx_cyc   = cyc;
        @(negedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] b);
        exp_q.push_back(model_echo(b));
        send(b);
    endtask

    task automatic wait_count(input int target, input int budget, input string tag);
        int n = 0;
        while (tx_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, tx_count, target);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(2);

        // Basic session: 0x41, 0x42, terminator.
        activate = 1'b1;
        idle(1);
        base = tx_count;
        send_exp(8'h41);
        wait_count(base + 1, 20, "first_echo");
        check("rx_to_tx_latency", last_start_cyc - rx_cyc, 2);
        send_exp(8'h42);
        send_exp(8'h1B);
        wait_count(base + 3, 100, "basic_echo_count");
        begin
            int n = 0;
            while (tx_done !== 1'b1 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("term_tx_done_seen", {31'd0, tx_done}, 32'd1);
        check("done_before_term_done", {31'd0, done}, 32'd0);
        idle(1);
        check("done_one_cycle_after", {31'd0, done}, 32'd1);
        idle(5);
        check("done_held", {31'd0, done}, 32'd1);
        check("tx_data_held", {24'd0, tx_data}, 32'h1B);
        activate = 1'b0;
        idle(1);
        check("done_clears", {31'd0, done}, 32'd0);

        // Inactive receive ignored; rx_ready in the activation cycle ignored.
        idle(2);
        base = tx_count;
        send(8'h55);
        idle(10);
        check("inactive_no_echo", tx_count, base);
        @(negedge clk);
        #1;
        activate = 1'b1;
        rx_data  = 8'h66;
        rx_ready = 1'b1;
        @(negedge clk);
        #1;
        rx_ready = 1'b0;
        send_exp(8'h1B);
        wait_done(100, "done_after_lone_term");
        check("lone_term_count", tx_count, base + 1);
        activate = 1'b0;
        idle(3);

        // Overflow with a stalled transmitter.
        tx_stall = 1'b1;
        activate = 1'b1;
        idle(2);
        base = tx_count;
        for (int i = 0; i < 18; i++) begin
            bv = 8'h80 + 8'(i);
            if (i < 17) exp_q.push_back(model_echo(bv));
            send(bv);
            if (i == 16) check("no_overflow_at_full", {31'd0, overflow}, 32'd0);
        end
        check("overflow_set", {31'd0, overflow}, 32'd1);
        check("stalled_in_flight", tx_count, base + 1);
        tx_stall = 1'b0;
        wait_count(base + 17, 600, "overflow_echo_count");
        idle(20);
        check("no_extra_echo", tx_count, base + 17);
        check("overflow_sticky", {31'd0, overflow}, 32'd1);
        send_exp(8'h1B);
        wait_done(100, "done_after_overflow");
        activate = 1'b0;
        idle(3);
        check("overflow_cleared_idle", {31'd0, overflow}, 32'd0);

        // activate drops while a byte is buffered.
        tx_stall = 1'b1;
        activate = 1'b1;
        idle(1);
        base = tx_count;
        send_exp(8'h31);
        send(8'h32);
        idle(2);
        check("drop_in_flight", tx_count, base + 1);
        activate = 1'b0;
        idle(2);
        tx_stall = 1'b0;
        idle(20);
        check("dropped_not_sent", tx_count, base + 1);
        check("drop_done_low", {31'd0, done}, 32'd0);

        // Reset mid-session.
        tx_stall = 1'b1;
        activate = 1'b1;
        idle(1);
        base = tx_count;
        send_exp(8'h44);
        send(8'h45);
        idle(2);
        reset    = 1'b0;
        activate = 1'b0;
        #1;
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        idle(2);
        reset    = 1'b1;
        tx_stall = 1'b0;
        idle(20);
        check("mid_rst_no_echo", tx_count, base + 1);

        // Lower-case session (converted only when the feature is built in).
        activate = 1'b1;
        idle(1);
        base = tx_count;
        send_exp(8'h61);
        send_exp(8'h7A);
        send_exp(8'h5B);
        send_exp(8'h1B);
        wait_count(base + 4, 200, "case_echo_count");
        wait_done(50, "case_done");
        activate = 1'b0;
        idle(3);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
